// File: rtl/vmem_wr_arbiter_pkg.sv
// Shared widths, defaults and state encoding for the video-memory write arbiter.
package vmem_wr_arbiter_pkg;
  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 24;
  localparam int H_W          = 10;
  localparam int V_W          = 9;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [H_W-1:0] h,
                                                  input logic [V_W-1:0] v);
    return {h, v};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last gets the grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_q;

  always_comb begin
    gnt = req;
    if (&req) gnt = last_q ? 2'b01 : 2'b10;
  end

  // last_q resets to 1 so requester 0 takes the first tie
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)      last_q <= 1'b1;
    else if (advance) last_q <= gnt[1];
endmodule

// File: rtl/vmem_wr_arbiter.sv
// Single vmem write port shared by two requesters, with a pre-empting clear-screen fill engine.
module vmem_wr_arbiter
  import vmem_wr_arbiter_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vga_valid,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [H_W-1:0]    req0_h,
  input  logic [V_W-1:0]    req0_v,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [H_W-1:0]    req1_h,
  input  logic [V_W-1:0]    req1_v,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              err_oob
);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_ACTIVE - 1);

  state_e              state_q;
  logic [H_W-1:0]      fh_q;
  logic [V_W-1:0]      fv_q;
  logic [DATA_W-1:0]   color_q;
  logic                mem_we_q, busy_q, done_q, oob_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                allowed, in_idle, xfer, sel_oob;
  logic [1:0]          gnt;
  logic [H_W-1:0]      sel_h;
  logic [V_W-1:0]      sel_v;
  logic [DATA_W-1:0]   sel_d;

  assign allowed    = ~BLANK_ONLY | ~vga_valid;
  assign in_idle    = (state_q == ST_IDLE);
  assign req0_ready = in_idle & allowed & gnt[0];
  assign req1_ready = in_idle & allowed & gnt[1];
  assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign sel_h   = gnt[1] ? req1_h    : req0_h;
  assign sel_v   = gnt[1] ? req1_v    : req0_v;
  assign sel_d   = gnt[1] ? req1_data : req0_data;
  assign sel_oob = (sel_h > H_LAST) | (sel_v > V_LAST);

  rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     ({req1_valid, req0_valid}),
    .advance (xfer),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      fh_q     <= '0;
      fv_q     <= '0;
      color_q  <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // accepted out-of-range requests are acked but dropped
          if (xfer) begin
            if (sel_oob) oob_q <= 1'b1;
            else begin
              mem_we_q <= 1'b1;
              addr_q   <= pack_addr(sel_h, sel_v);
              wdata_q  <= sel_d;
            end
          end
          if (clear_start) begin
            state_q <= ST_FILL;
            color_q <= clear_color;
            fh_q    <= '0;
            fv_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (allowed) begin
            mem_we_q <= 1'b1;
            addr_q   <= pack_addr(fh_q, fv_q);
            wdata_q  <= color_q;
            if (fh_q == H_LAST) begin
              fh_q <= '0;
              // busy drops and done pulses alongside the final write on mem_we
              if (fv_q == V_LAST) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                fv_q <= fv_q + V_W'(1);
              end
            end else begin
              fh_q <= fh_q + H_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;
  assign err_oob   = oob_q;
endmodule

// File: tb/tb_vmem_wr_arbiter.sv
// Scoreboard bench for vmem_wr_arbiter on a reduced 16x8 screen with blank-only gating.
module tb_vmem_wr_arbiter;
  localparam int HA = 16;
  localparam int VA = 8;

  typedef struct {
    logic        oob;
    logic [18:0] addr;
    logic [23:0] data;
    logic        done;
    logic        cbusy;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0, resetn = 1'b1, vga_valid = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, clear_start = 1'b0;
  logic [9:0]  req0_h = '0, req1_h = '0;
  logic [8:0]  req0_v = '0, req1_v = '0;
  logic [23:0] req0_data = '0, req1_data = '0, clear_color = '0;
  logic        req0_ready, req1_ready, mem_we, fill_busy, fill_done, err_oob;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;

  int   n_vec = 0, n_err = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  vmem_wr_arbiter #(.H_ACTIVE(HA), .V_ACTIVE(VA), .BLANK_ONLY(1'b1)) dut (
    .clk(clk), .resetn(resetn), .vga_valid(vga_valid),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_h(req0_h), .req0_v(req0_v), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_h(req1_h), .req1_v(req1_v), .req1_data(req1_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_busy(fill_busy), .fill_done(fill_done), .err_oob(err_oob)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_w(input logic [9:0] h, input logic [8:0] v, input logic [23:0] d);
    exp_t e;
    e.oob = 1'b0; e.addr = {h, v}; e.data = d; e.done = 1'b0; e.cbusy = 1'b0; e.busy = 1'b0;
    q.push_back(e);
  endfunction

  function automatic void push_o();
    exp_t e;
    e.oob = 1'b1; e.addr = '0; e.data = '0; e.done = 1'b0; e.cbusy = 1'b0; e.busy = 1'b0;
    q.push_back(e);
  endfunction

  function automatic void push_f(input logic [9:0] h, input logic [8:0] v, input logic [23:0] d,
                                 input logic last);
    exp_t e;
    e.oob = 1'b0; e.addr = {h, v}; e.data = d; e.done = last; e.cbusy = 1'b1; e.busy = ~last;
    q.push_back(e);
  endfunction

  // Monitor: every mem_we / err_oob must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (mem_we || err_oob) begin
        if (q.size() == 0) chk("unexpected_out", {30'd0, mem_we, err_oob}, 32'd0);
        else begin
          e = q.pop_front();
          chk("out_kind", {30'd0, mem_we, err_oob}, e.oob ? 32'd1 : 32'd2);
          if (!e.oob) begin
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
            chk("fill_done", 32'(fill_done), 32'(e.done));
            if (e.cbusy) chk("fill_busy_on_write", 32'(fill_busy), 32'(e.busy));
          end
        end
      end else if (fill_done) begin
        chk("stray_fill_done", 32'(fill_done), 32'd0);
      end
    end
  end

  task automatic cyc(input logic vg, input logic cs, input logic [23:0] cc,
                     input logic v0, input logic [9:0] h0, input logic [8:0] y0, input logic [23:0] d0,
                     input logic v1, input logic [9:0] h1, input logic [8:0] y1, input logic [23:0] d1,
                     input logic e0, input logic e1);
    @(posedge clk); #1;
    vga_valid = vg; clear_start = cs; clear_color = cc;
    req0_valid = v0; req0_h = h0; req0_v = y0; req0_data = d0;
    req1_valid = v1; req1_h = h1; req1_v = y1; req1_data = d1;
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    if (e0 && v0) begin
      if (h0 >= 10'(HA) || y0 >= 9'(VA)) push_o(); else push_w(h0, y0, d0);
    end
    if (e1 && v1) begin
      if (h1 >= 10'(HA) || y1 >= 9'(VA)) push_o(); else push_w(h1, y1, d1);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_chk();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_fill_busy", 32'(fill_busy), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    chk("rst_err_oob", 32'(err_oob), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
  endtask

  task automatic do_reset();
    vga_valid = 0; clear_start = 0; req0_valid = 0; req1_valid = 0;
    resetn = 1'b0;
    #1 rst_chk();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #3 do_reset();

    // single request on requester 0
    cyc(0, 0, 0, 1, 10'd5, 9'd7, 24'hFF0000, 0, 0, 0, 0, 1, 0);
    idle(); drain();

    // both valid after reset: 0,1,0,1
    do_reset();
    cyc(0, 0, 0, 1, 10'd1, 9'd2, 24'h000100, 1, 10'd10, 9'd3, 24'hAB0000, 1, 0);
    cyc(0, 0, 0, 1, 10'd2, 9'd2, 24'h000101, 1, 10'd10, 9'd3, 24'hAB0000, 0, 1);
    cyc(0, 0, 0, 1, 10'd2, 9'd2, 24'h000101, 1, 10'd11, 9'd3, 24'hAB0001, 1, 0);
    cyc(0, 0, 0, 1, 10'd3, 9'd2, 24'h000102, 1, 10'd11, 9'd3, 24'hAB0001, 0, 1);
    idle(); drain();

    // active video blocks the handshake until blanking
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 10'd4, 9'd5, 24'h123456, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 10'd4, 9'd5, 24'h123456, 0, 1);
    idle(); drain();

    // out-of-range and edge-of-screen requests
    cyc(0, 0, 0, 1, 10'd16, 9'd0, 24'hDEAD01, 0, 0, 0, 0, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 10'd0, 9'd8, 24'hDEAD02, 0, 1);
    cyc(0, 0, 0, 1, 10'd15, 9'd7, 24'h0F0F0F, 0, 0, 0, 0, 1, 0);
    idle(); drain();

    // full fill with a concurrent request in the start cycle, a stall and an ignored restart
    cyc(0, 1, 24'h00FF00, 1, 10'd3, 9'd4, 24'h777777, 0, 0, 0, 0, 1, 0);
    for (int v = 0; v < VA; v++)
      for (int h = 0; h < HA; h++)
        push_f(10'(h), 9'(v), 24'h00FF00, (h == HA-1) && (v == VA-1));
    for (int i = 0; i < HA*VA + 3; i++) begin
      cyc((i >= 20 && i <= 22), (i == 50), 24'h0000FF,
          1, 10'd1, 9'd1, 24'h111111, 1, 10'd2, 9'd1, 24'hABCDEF, 0, 0);
      chk("fill_busy_during", 32'(fill_busy), 32'd1);
    end
    cyc(0, 0, 0, 1, 10'd1, 9'd1, 24'h111111, 1, 10'd2, 9'd1, 24'hABCDEF, 0, 1);
    idle(); drain();
    chk("fill_busy_after", 32'(fill_busy), 32'd0);

    // reset during a fill aborts it; arbitration restarts with requester 0
    cyc(0, 1, 24'h123123, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) push_f(10'(i), 9'd0, 24'h123123, 1'b0);
    for (int i = 0; i < 10; i++) idle();
    #2 resetn = 1'b0;
    #1 rst_chk();
    @(posedge clk);
    @(negedge clk);
    rst_chk();
    resetn = 1'b1;
    chk("abort_queue_empty", 32'(q.size()), 32'd0);
    cyc(0, 0, 0, 1, 10'd6, 9'd6, 24'h606060, 1, 10'd7, 9'd7, 24'h707070, 1, 0);
    idle(); drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vmem_wr_arbiter.md
Name: vmem_wr_arbiter

Overview:
- Owns the single write port of the 24-bit video memory, addressed as {h[9:0], v[8:0]}, that feeds vga_ctrl scanout.
- Shares that port between two write requesters using valid/ready handshakes and round-robin arbitration.
- Requester 0 is the text/keyboard renderer; requester 1 is the UART image loader.
- Contains a clear-screen fill engine that writes one colour over the whole active area and pre-empts both requesters while it runs.

Parameters:
- H_ACTIVE, 640: visible columns; h range is 0..H_ACTIVE-1.
- V_ACTIVE, 480: visible rows; v range is 0..V_ACTIVE-1.
- BLANK_ONLY, 1: when 1, writes are issued only while vga_valid=0; when 0, writes are issued on any cycle.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- vga_valid  in  1  vga_ctrl active-video flag; gates writes when BLANK_ONLY=1.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req0_h  in  10  requester 0 column.
- req0_v  in  9  requester 0 row.
- req0_data  in  24  requester 0 RGB888 pixel.
- req1_valid, req1_ready, req1_h, req1_v, req1_data: same widths and meaning for requester 1.
- clear_start  in  1  one-cycle pulse that starts a fill.
- clear_color  in  24  fill colour, sampled on clear_start.
- mem_we  out  1  write strobe to vmem.
- mem_addr  out  19  {h, v} write address.
- mem_wdata  out  24  write data.
- fill_busy  out  1  fill engine is active.
- fill_done  out  1  one-cycle pulse after the last fill write.
- err_oob  out  1  one-cycle pulse when an accepted request was out of range and dropped.

Behaviour:
- Reset values: all outputs 0; state=IDLE; fill counters 0; last_grant=1, so req0 wins the first tie. Reset is asynchronous and takes effect at any point, including mid-fill: the fill aborts and no fill_done is produced.
- allowed = (BLANK_ONLY==0) | ~vga_valid.
- States: IDLE and FILL.
- IDLE, requester handshake:
  - Only one valid: that requester gets the grant.
  - Both valid: the requester other than last_grant gets the grant.
  - reqN_ready = (state==IDLE) & allowed & grant_N. This is combinational; at most one ready is high per cycle.
  - A transfer occurs when valid & ready are both high; last_grant is updated to N on that transfer.
  - While allowed=0, no ready is asserted and last_grant is held.
  - Requesters must hold h, v and data stable while valid is high and ready is low.
- Write port timing:
  - Transfer in cycle t gives mem_we=1 in cycle t+1, with mem_addr={h,v} and mem_wdata=data registered.
  - mem_we is otherwise 0. mem_addr and mem_wdata hold their last value when mem_we=0.
- Out-of-range requests:
  - A transfer with h>=H_ACTIVE or v>=V_ACTIVE is still acknowledged (ready=1).
  - No mem_we is issued; err_oob=1 in cycle t+1.
- Fill start:
  - clear_start in IDLE: latch clear_color, set fh=0 and fv=0, state becomes FILL next cycle, fill_busy=1 from the next cycle.
  - A requester transfer in the same cycle as clear_start still completes normally.
  - clear_start while in FILL is ignored; the colour is not re-latched.
- FILL:
  - Both readys are 0.
  - Each cycle with allowed=1, issue a registered write (mem_we=1 next cycle) of {fh,fv} with the latched colour, then advance the counters.
  - Counter advance: fh++; when fh==H_ACTIVE-1, fh=0 and fv++.
  - Cycles with allowed=0 stall the counters with no write.
- Fill end:
  - The write of (H_ACTIVE-1, V_ACTIVE-1) is the last; state returns to IDLE.
  - fill_busy=0 and fill_done=1 in the cycle that write appears on mem_we.
  - With default parameters and BLANK_ONLY=0, a fill is exactly 307200 writes.
  - Requesters may receive ready in the cycle after the last fill write issues; arbitration resumes from the preserved last_grant.
- Width rules: fh is 10 bits and fv is 9 bits, compared against parameter-1. No wrap occurs past V_ACTIVE-1.

Decomposition:
- vmem_defs.vh: ADDR_W=19, DATA_W=24, H_W=10, V_W=9, default H_ACTIVE/V_ACTIVE, state encodings ST_IDLE and ST_FILL.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, resetn, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - Holds last_grant.
- Top-level wiring: instantiate vmem_wr_arbiter in top between the pixel sources and the vmem write port. vmem's read side is unchanged.

Test Plan:
- req0 only, h=5, v=7, data=FF0000, BLANK_ONLY=0 -> ready same cycle; next cycle mem_we=1, mem_addr={10'd5,9'd7}, mem_wdata=FF0000.
- Both valid continuously for 4 cycles -> readys go 0,1,0,1 (req0 first after reset); mem_we=1 on each of the 4 following cycles.
- BLANK_ONLY=1, vga_valid=1, req1_valid=1 -> req1_ready stays 0; drop vga_valid -> ready=1 that cycle, write the next.
- req0 with h=640, v=0 -> ready=1, no mem_we, err_oob pulses once in the next cycle.
- clear_start with color=00FF00, BLANK_ONLY=0 -> 307200 consecutive writes from {0,0} to {639,479}; fill_busy high throughout; fill_done single pulse on the last write; readys 0 during the fill; a second clear_start mid-fill has no effect.
- resetn asserted mid-fill -> all outputs 0 immediately, no fill_done; after release, req0 wins the first tie.
